// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, control word types and the opcode decoder.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic    reg_write;
    logic    alu_src;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  illegal;
    logic  use_rs1;
    logic  use_rs2;
  } dec_t;

  // alt is instr[30]; it selects SUB only for register-register ops, SRA for both shift forms
  function automatic alu_op_e alu_from_f3(input logic [2:0] funct3, input logic alt,
                                          input logic is_reg);
    alu_op_e r;
    r = ALU_ADD;
    case (funct3)
      3'd0: r = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'd1: r = ALU_SLL;
      3'd2: r = ALU_SLT;
      3'd3: r = ALU_SLTU;
      3'd4: r = ALU_XOR;
      3'd5: r = alt ? ALU_SRA : ALU_SRL;
      3'd6: r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    t = IMM_NONE;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: t = IMM_I;
      OPC_STORE:                      t = IMM_S;
      OPC_BRANCH:                     t = IMM_B;
      OPC_LUI, OPC_AUIPC:             t = IMM_U;
      OPC_JAL:                        t = IMM_J;
      default:                        t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic dec_t decode(input logic [6:0] opcode, input logic [2:0] funct3,
                                  input logic alt);
    dec_t d;
    d = '0;
    case (opcode)
      OPC_LUI: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_op    = ALU_PASSB;
      end
      OPC_AUIPC: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
      end
      OPC_JAL: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.jump      = 1'b1;
      end
      OPC_JALR: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.jump      = 1'b1;
        d.use_rs1        = 1'b1;
      end
      OPC_BRANCH: begin
        d.ctrl.branch = 1'b1;
        d.ctrl.alu_op = (funct3[2:1] == 2'b10) ? ALU_SLT :
                        (funct3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
        d.use_rs1     = 1'b1;
        d.use_rs2     = 1'b1;
      end
      OPC_LOAD: begin
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
        d.ctrl.mem_read   = 1'b1;
        d.use_rs1         = 1'b1;
      end
      OPC_STORE: begin
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.mem_write = 1'b1;
        d.use_rs1        = 1'b1;
        d.use_rs2        = 1'b1;
      end
      OPC_OP_IMM: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_op    = alu_from_f3(funct3, alt, 1'b0);
        d.use_rs1        = 1'b1;
      end
      OPC_OP: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_op    = alu_from_f3(funct3, alt, 1'b1);
        d.use_rs1        = 1'b1;
        d.use_rs2        = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate generator, sign-extended to XLEN.
module imm_gen import riscv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type_of(instr_i[6:0]))
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV32I decode with register file, load-use stall and ID/EX register.
module id_ex_stage import riscv_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int WB_BYPASS = 1,
  parameter int LU_STALL  = 1,
  localparam int RA_W     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output ctrl_t           out_ctrl,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [RA_W-1:0] out_rd,
  output logic [RA_W-1:0] out_rs1,
  output logic [RA_W-1:0] out_rs2,
  output logic            out_illegal
);

  logic [XLEN-1:0] rf_q [NREGS];

  dec_t            dec;
  logic [RA_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] rs1_rd, rs2_rd, imm;
  logic            lu_hazard, load;

  logic            valid_q, valid_d;
  ctrl_t           ctrl_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q, pc_q;
  logic [RA_W-1:0] rd_q, rs1_q, rs2_q;
  logic            illegal_q;

  assign dec = decode(in_instr[6:0], in_instr[14:12], in_instr[30]);
  assign rd  = RA_W'(in_instr[11:7]);
  assign rs1 = RA_W'(in_instr[19:15]);
  assign rs2 = RA_W'(in_instr[24:20]);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (in_instr),
    .imm_o   (imm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // x0 reads zero regardless of array contents; the bypass covers the same-edge WB write
  always_comb begin
    rs1_rd = rf_q[rs1];
    rs2_rd = rf_q[rs2];
    if (rs1 == '0) rs1_rd = '0;
    else if (WB_BYPASS != 0 && wb_we && wb_rd == rs1) rs1_rd = wb_data;
    if (rs2 == '0) rs2_rd = '0;
    else if (WB_BYPASS != 0 && wb_we && wb_rd == rs2) rs2_rd = wb_data;
  end

  assign lu_hazard = (LU_STALL != 0) && valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                     ((dec.use_rs1 && rd_q == rs1) || (dec.use_rs2 && rd_q == rs2)) &&
                     in_valid;
  assign in_ready  = (!valid_q || out_ready) && !lu_hazard && !flush;
  assign load      = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (load)      valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        ctrl_q     <= dec.ctrl;
        rs1_data_q <= rs1_rd;
        rs2_data_q <= rs2_rd;
        imm_q      <= imm;
        pc_q       <= in_pc;
        rd_q       <= rd;
        rs1_q      <= rs1;
        rs2_q      <= rs2;
        illegal_q  <= dec.illegal;
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_ctrl     = ctrl_q;
  assign out_rs1_data = rs1_data_q;
  assign out_rs2_data = rs2_data_q;
  assign out_imm      = imm_q;
  assign out_pc       = pc_q;
  assign out_rd       = rd_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed vector bench for id_ex_stage.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, wb_we, out_ready;
  logic [31:0] in_instr, in_pc, wb_data;
  logic [4:0]  wb_rd;

  logic        in_ready, out_valid, out_illegal;
  ctrl_t       out_ctrl;
  logic [31:0] out_rs1_data, out_rs2_data, out_imm, out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  logic        n_in_ready, n_out_valid, n_out_illegal;
  ctrl_t       n_out_ctrl;
  logic [31:0] n_out_rs1_data, n_out_rs2_data, n_out_imm, n_out_pc;
  logic [4:0]  n_out_rd, n_out_rs1, n_out_rs2;

  int total = 0;
  int bad   = 0;
  int fire8 = 0;
  int fire9 = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_illegal(out_illegal)
  );

  id_ex_stage #(.WB_BYPASS(0), .LU_STALL(0)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_ctrl(n_out_ctrl),
    .out_rs1_data(n_out_rs1_data), .out_rs2_data(n_out_rs2_data), .out_imm(n_out_imm),
    .out_pc(n_out_pc), .out_rd(n_out_rd), .out_rs1(n_out_rs1), .out_rs2(n_out_rs2),
    .out_illegal(n_out_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && out_rd == 5'd8) fire8++;
    if (!rst && out_valid && out_ready && out_rd == 5'd9) fire9++;
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [10:0] ctrl;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string name, input logic [31:0] instr, input logic [10:0] ctrl,
                         input logic [31:0] imm, input logic [31:0] rs1d,
                         input logic [31:0] rs2d, input logic [4:0] rd, input logic ill);
    vec_t v;
    v.name = name; v.instr = instr; v.pc = 32'h1000 + 32'(vq.size() * 4);
    v.ctrl = ctrl; v.imm = imm; v.rs1d = rs1d; v.rs2d = rs2d; v.rd = rd; v.ill = ill;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] acc;
    int b8, b9;

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 32'h0; wb_data = 32'h0; wb_rd = 5'd0;

    // reset
    tick(); tick();
    check("rst.out_valid", {31'b0, out_valid}, 32'h0);
    check("rst.out_imm", out_imm, 32'h0);
    check("rst.out_ctrl", {21'b0, out_ctrl}, 32'h0);
    check("rst.in_ready", {31'b0, in_ready}, 32'h1);
    rst = 1'b0;

    // every register reads zero after reset
    acc = 32'h0;
    in_valid = 1'b1;
    for (int r = 1; r < 32; r++) begin
      in_instr = {7'b0, 5'(r), 5'(r), 3'b0, 5'd0, 7'h33};
      tick();
      acc = acc | out_rs1_data | out_rs2_data;
    end
    in_valid = 1'b0;
    check("rst.regs_zero", acc, 32'h0);
    tick();

    // WB to x0 must not bypass into an x0 read
    in_valid = 1'b1; in_instr = 32'h00000433;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0; wb_we = 1'b0;
    check("x0.bypass", out_rs1_data, 32'h0);
    tick();

    // same-cycle WB bypass: addi x6,x5,-1 while x5 <= 0x1234
    in_valid = 1'b1; in_instr = 32'hFFF28313;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h00001234;
    tick();
    in_valid = 1'b0; wb_we = 1'b0;
    check("byp.rs1_data", out_rs1_data, 32'h00001234);
    check("byp.imm", out_imm, 32'hFFFFFFFF);
    check("byp.alu_src", {31'b0, out_ctrl.alu_src}, 32'h1);
    check("nobyp.rs1_data", n_out_rs1_data, 32'h0);
    tick();

    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h00000100; tick();
    wb_rd = 5'd2; wb_data = 32'h00000022; tick();
    wb_we = 1'b0;

    add_vec("add",   32'h00208433, 11'b10000000000, 32'h00000000, 32'h100,  32'h22, 5'd8,  1'b0);
    add_vec("sub",   32'h402084B3, 11'b10000000001, 32'h00000000, 32'h100,  32'h22, 5'd9,  1'b0);
    add_vec("slt",   32'h0020A633, 11'b10000000011, 32'h00000000, 32'h100,  32'h22, 5'd12, 1'b0);
    add_vec("sw",    32'h0020A423, 11'b01001000000, 32'h00000008, 32'h100,  32'h22, 5'd8,  1'b0);
    add_vec("lw",    32'hFFC12383, 11'b11110000000, 32'hFFFFFFFC, 32'h22,   32'h0,  5'd7,  1'b0);
    add_vec("srai",  32'h4040D513, 11'b11000000111, 32'h00000404, 32'h100,  32'h0,  5'd10, 1'b0);
    add_vec("jalr",  32'h00C100E7, 11'b11000010000, 32'h0000000C, 32'h22,   32'h0,  5'd1,  1'b0);
    add_vec("auipc", 32'h12345197, 11'b11000000000, 32'h12345000, 32'h0,    32'h0,  5'd3,  1'b0);
    add_vec("lui",   32'hABCDE0B7, 11'b11000001010, 32'hABCDE000, 32'h0,    32'h0,  5'd1,  1'b0);
    add_vec("beq",   32'hFE000EE3, 11'b00000100001, 32'hFFFFFFFC, 32'h0,    32'h0,  5'd29, 1'b0);
    add_vec("jal",   32'h8000006F, 11'b10000010000, 32'hFFF00000, 32'h0,    32'h0,  5'd0,  1'b0);
    add_vec("ill",   32'h0000007F, 11'b00000000000, 32'h00000000, 32'h0,    32'h0,  5'd0,  1'b1);
    add_vec("addi",  32'h06428593, 11'b11000000000, 32'h00000064, 32'h1234, 32'h0,  5'd11, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      in_valid = 1'b1; in_instr = vq[i].instr; in_pc = vq[i].pc;
      tick();
      in_valid = 1'b0;
      check({vq[i].name, ".valid"},   {31'b0, out_valid}, 32'h1);
      check({vq[i].name, ".ctrl"},    {21'b0, out_ctrl}, {21'b0, vq[i].ctrl});
      check({vq[i].name, ".imm"},     out_imm, vq[i].imm);
      check({vq[i].name, ".rs1d"},    out_rs1_data, vq[i].rs1d);
      check({vq[i].name, ".rs2d"},    out_rs2_data, vq[i].rs2d);
      check({vq[i].name, ".rd"},      {27'b0, out_rd}, {27'b0, vq[i].rd});
      check({vq[i].name, ".illegal"}, {31'b0, out_illegal}, {31'b0, vq[i].ill});
      check({vq[i].name, ".pc"},      out_pc, vq[i].pc);
      tick();
    end

    // load-use: lw x7,0(x1) then add x8,x7,x2
    in_valid = 1'b1; in_instr = 32'h0000A383;
    tick();
    in_instr = 32'h00238433;
    #1;
    check("lu.in_ready_stall", {31'b0, in_ready}, 32'h0);
    check("lu.nostall_in_ready", {31'b0, n_in_ready}, 32'h1);
    tick();
    check("lu.bubble", {31'b0, out_valid}, 32'h0);
    check("lu.in_ready_after", {31'b0, in_ready}, 32'h1);
    check("lu.nostall_issued", {26'b0, n_out_valid, n_out_rd}, {26'b0, 1'b1, 5'd8});
    tick();
    in_valid = 1'b0;
    check("lu.add_valid", {31'b0, out_valid}, 32'h1);
    check("lu.add_rd", {27'b0, out_rd}, 32'd8);
    check("lu.add_ctrl", {21'b0, out_ctrl}, {21'b0, 11'b10000000000});
    tick();
    tick();

    // backpressure: out_ready low for 3 cycles with a second instruction waiting
    b8 = fire8; b9 = fire9;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00208433;
    tick();
    in_instr = 32'h402084B3;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp.in_ready%0d", k), {31'b0, in_ready}, 32'h0);
      check($sformatf("bp.hold%0d", k), {26'b0, out_valid, out_rd}, {26'b0, 1'b1, 5'd8});
      check($sformatf("bp.data%0d", k), out_rs1_data ^ out_rs2_data, 32'h122);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", {31'b0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    check("bp.next_rd", {26'b0, out_valid, out_rd}, {26'b0, 1'b1, 5'd9});
    tick();
    check("bp.drained", {31'b0, out_valid}, 32'h0);
    check("bp.fire8_once", 32'(fire8 - b8), 32'd1);
    check("bp.fire9_once", 32'(fire9 - b9), 32'd1);

    // flush with a held and an incoming instruction, plus a WB in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00208433;
    tick();
    in_instr = 32'h402084B3; flush = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h00000055;
    #1;
    check("fl.in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0; wb_we = 1'b0;
    check("fl.killed", {31'b0, out_valid}, 32'h0);
    tick();
    check("fl.dropped", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00018433;
    tick();
    in_valid = 1'b0;
    check("fl.wb_committed", out_rs1_data, 32'h00000055);
    tick();

    // reset in the middle of a load-use stall
    in_valid = 1'b1; in_instr = 32'h0000A383;
    tick();
    in_instr = 32'h00238433; out_ready = 1'b0;
    #1;
    check("rs.stalled", {31'b0, in_ready}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rs.out_valid", {31'b0, out_valid}, 32'h0);
    check("rs.no_hazard", {31'b0, in_ready}, 32'h1);
    out_ready = 1'b1; in_instr = 32'h00208433;
    tick();
    in_valid = 1'b0;
    check("rs.regs_cleared", out_rs1_data | out_rs2_data, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
